// File: rtl/uart_rx_bit_timer.sv
// rtl/uart_rx_bit_timer.sv - oversampling edge/bit timer for the UART receiver
module uart_rx_bit_timer #(
  parameter int PRESCALE_W    = 6,
  parameter int MIN_PRESCALE  = 4,
  parameter int MAX_DATA_BITS = 9,
  parameter int BIT_CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [3:0]            data_len,
  input  logic                  par_en,
  input  logic                  stop2,
  input  logic                  counter_enable,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count,
  output logic                  busy,
  output logic                  samp_en,
  output logic                  samp_last,
  output logic                  is_start,
  output logic                  is_data,
  output logic                  is_par,
  output logic                  is_stop,
  output logic                  frame_done,
  output logic                  presc_err
);

  localparam logic [PRESCALE_W-1:0] MIN_P = PRESCALE_W'(MIN_PRESCALE);
  localparam logic [PRESCALE_W-1:0] ONE_P = PRESCALE_W'(1);
  localparam logic [3:0]            MIN_L = 4'd5;
  localparam logic [3:0]            MAX_L = 4'(MAX_DATA_BITS);
  localparam logic [BIT_CNT_W-1:0]  ONE_B = BIT_CNT_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [3:0]            l_q, l_d;
  logic                  par_q, par_d;
  logic                  stop2_q, stop2_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  presc_legal;
  logic [3:0]            len_clamped;
  logic [PRESCALE_W-1:0] p_last;
  logic [PRESCALE_W-1:0] half;
  logic [BIT_CNT_W-1:0]  len_b;
  logic [BIT_CNT_W-1:0]  bit_last;
  logic                  run;
  logic                  dec_start, dec_data, dec_par;

  assign presc_legal = (prescale >= MIN_P) && !prescale[0];
  assign len_clamped = (data_len < MIN_L) ? MIN_L :
                       (data_len > MAX_L) ? MAX_L : data_len;

  // Frame geometry comes from the latched copy so input changes mid-frame are inert.
  assign p_last   = p_q - ONE_P;
  assign half     = p_q >> 1;
  assign len_b    = BIT_CNT_W'(l_q);
  assign bit_last = len_b + BIT_CNT_W'(par_q) + (stop2_q ? BIT_CNT_W'(2) : ONE_B);

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    p_d     = p_q;
    l_d     = l_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    done_d  = 1'b0;
    err_d   = err_q;
    if (!counter_enable) begin
      state_d = IDLE;
      edge_d  = '0;
      bit_d   = '0;
    end else if (state_q == IDLE) begin
      edge_d = '0;
      bit_d  = '0;
      if (presc_legal) begin
        state_d = RUN;
        edge_d  = ONE_P;
        p_d     = prescale;
        l_d     = len_clamped;
        par_d   = par_en;
        stop2_d = stop2;
        err_d   = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (edge_q >= p_last) begin
      // >= rather than == keeps the counters bounded even from a corrupted value.
      edge_d = '0;
      if (bit_q >= bit_last) begin
        bit_d   = '0;
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        bit_d = bit_q + ONE_B;
      end
    end else begin
      edge_d = edge_q + ONE_P;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      p_q     <= '0;
      l_q     <= '0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      p_q     <= p_d;
      l_q     <= l_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign run       = (state_q == RUN);
  assign dec_start = (bit_q == '0);
  assign dec_data  = (bit_q != '0) && (bit_q <= len_b);
  assign dec_par   = par_q && (bit_q == len_b + ONE_B);

  assign edge_count = edge_q;
  assign bit_count  = bit_q;
  assign busy       = run;
  assign samp_en    = run && ((edge_q == half - ONE_P) || (edge_q == half) ||
                              (edge_q == half + ONE_P));
  assign samp_last  = run && (edge_q == half + ONE_P);
  assign is_start   = run && dec_start;
  assign is_data    = run && dec_data;
  assign is_par     = run && dec_par;
  assign is_stop    = run && !dec_start && !dec_data && !dec_par;
  assign frame_done = done_q;
  assign presc_err  = err_q;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// tb/tb_uart_rx_bit_timer.sv - self-checking bench for uart_rx_bit_timer
module tb_uart_rx_bit_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] prescale;
  logic [3:0] data_len;
  logic       par_en, stop2, counter_enable;
  logic [5:0] edge_count;
  logic [3:0] bit_count;
  logic       busy, samp_en, samp_last, is_start, is_data, is_par, is_stop;
  logic       frame_done, presc_err;

  uart_rx_bit_timer dut (
    .clk(clk), .rst(rst), .prescale(prescale), .data_len(data_len),
    .par_en(par_en), .stop2(stop2), .counter_enable(counter_enable),
    .edge_count(edge_count), .bit_count(bit_count), .busy(busy),
    .samp_en(samp_en), .samp_last(samp_last), .is_start(is_start),
    .is_data(is_data), .is_par(is_par), .is_stop(is_stop),
    .frame_done(frame_done), .presc_err(presc_err)
  );

  always #5 clk = ~clk;

  // Model: frame position is just elapsed cycles since the start cycle.
  int m_busy, m_k, m_done, m_err, m_P, m_L, m_par, m_s2;

  always @(posedge clk or negedge rst) begin : model
    int k, b, d, e, dl;
    if (!rst) begin
      m_busy <= 0; m_k <= 0; m_done <= 0; m_err <= 0;
      m_P <= 4; m_L <= 5; m_par <= 0; m_s2 <= 0;
    end else begin
      k = m_k; b = m_busy; e = m_err; d = 0;
      if (!counter_enable) begin
        b = 0; k = 0;
      end else if (m_busy == 0) begin
        if (prescale >= 4 && prescale % 2 == 0) begin
          dl = int'(data_len);
          m_P   <= int'(prescale);
          m_L   <= (dl < 5) ? 5 : (dl > 9) ? 9 : dl;
          m_par <= int'(par_en);
          m_s2  <= int'(stop2);
          b = 1; k = 1; e = 0;
        end else begin
          e = 1;
        end
      end else begin
        k = k + 1;
        if (k == (1 + m_L + m_par + (m_s2 != 0 ? 2 : 1)) * m_P) begin
          b = 0; k = 0; d = 1;
        end
      end
      m_k <= k; m_busy <= b; m_done <= d; m_err <= e;
    end
  end

  int errors = 0, checks = 0;
  int a_busy, a_done, a_done_idle, a_data, a_par, a_stop, a_sen, a_slast, a_start;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    int e_edge, e_bit, half, e_st, e_da, e_pa;
    e_edge = (m_busy != 0) ? m_k % m_P : 0;
    e_bit  = (m_busy != 0) ? m_k / m_P : 0;
    half   = m_P / 2;
    e_st = (m_busy != 0) && e_bit == 0;
    e_da = (m_busy != 0) && e_bit >= 1 && e_bit <= m_L;
    e_pa = (m_busy != 0) && m_par != 0 && e_bit == m_L + 1;
    chk("busy", busy, m_busy);
    chk("edge_count", edge_count, e_edge);
    chk("bit_count", bit_count, e_bit);
    chk("samp_en", samp_en, (m_busy != 0) && e_edge >= half - 1 && e_edge <= half + 1);
    chk("samp_last", samp_last, (m_busy != 0) && e_edge == half + 1);
    chk("is_start", is_start, e_st);
    chk("is_data", is_data, e_da);
    chk("is_par", is_par, e_pa);
    chk("is_stop", is_stop, (m_busy != 0) && !e_st && !e_da && !e_pa);
    chk("frame_done", frame_done, m_done);
    chk("presc_err", presc_err, m_err);
  endtask

  task automatic clr();
    a_busy = 0; a_done = 0; a_done_idle = 0; a_data = 0; a_par = 0;
    a_stop = 0; a_sen = 0; a_slast = 0; a_start = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      cmp_model();
      a_busy  += int'(busy);
      a_done  += int'(frame_done);
      a_done_idle += int'(frame_done && !busy);
      a_data  += int'(is_data);
      a_par   += int'(is_par);
      a_stop  += int'(is_stop);
      a_sen   += int'(samp_en);
      a_slast += int'(samp_last);
      a_start += int'(is_start);
    end
  endtask

  task automatic cfg(input int p, input int l, input int pe, input int s2);
    prescale = 6'(p); data_len = 4'(l); par_en = 1'(pe); stop2 = 1'(s2);
  endtask

  task automatic idle();
    counter_enable = 1'b0;
    run(2);
  endtask

  initial begin
    rst = 1'b0; counter_enable = 1'b0;
    cfg(8, 8, 0, 0);
    #3;
    chk("reset_outputs", {edge_count, bit_count, busy, samp_en, samp_last, is_start,
                          is_data, is_par, is_stop, frame_done, presc_err}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    run(2);

    // P=8 L=8 N=10
    clr(); counter_enable = 1'b1;
    run(80);
    chk("t1_busy_cycles", a_busy, 79);
    chk("t1_done", a_done, 1);
    chk("t1_samp_en", a_sen, 30);
    chk("t1_samp_last", a_slast, 10);
    idle();

    // P=16 L=7 parity, 2 stop: N=11
    cfg(16, 7, 1, 1); clr(); counter_enable = 1'b1;
    run(176);
    chk("t2_busy_cycles", a_busy, 175);
    chk("t2_par_cycles", a_par, 16);
    chk("t2_stop_cycles", a_stop, 32);
    chk("t2_data_cycles", a_data, 112);
    chk("t2_start_cycles", a_start, 15);
    chk("t2_done", a_done, 1);
    idle();

    // back-to-back, prescale changed mid frame 1
    cfg(32, 9, 0, 0); clr(); counter_enable = 1'b1;
    run(100);
    prescale = 6'd8;
    run(340);
    chk("t3_busy_cycles", a_busy, 438);
    chk("t3_done", a_done, 2);
    chk("t3_done_at_start", a_done_idle, 2);
    idle();

    // illegal prescale values, then recovery
    cfg(2, 8, 0, 0); clr(); counter_enable = 1'b1;
    run(3);
    chk("t4_err_p2", presc_err, 1);
    chk("t4_busy_p2", a_busy, 0);
    chk("t4_edge_p2", edge_count, 0);
    prescale = 6'd7;
    run(3);
    chk("t4_err_p7", presc_err, 1);
    chk("t4_busy_p7", a_busy, 0);
    prescale = 6'd8;
    run(1);
    chk("t4_err_clear", presc_err, 0);
    run(79);
    chk("t4_busy_cycles", a_busy, 79);
    chk("t4_done", a_done, 1);
    idle();

    // abort at bit 4 edge 3
    cfg(16, 8, 0, 0); clr(); counter_enable = 1'b1;
    run(67);
    chk("t5_bit_at_abort", bit_count, 4);
    chk("t5_edge_at_abort", edge_count, 3);
    counter_enable = 1'b0;
    run(1);
    chk("t5_cleared", {busy, bit_count, edge_count}, 0);
    run(5);
    chk("t5_no_done", a_done, 0);
    clr(); counter_enable = 1'b1;
    run(5);
    chk("t5_restart_bit", bit_count, 0);
    chk("t5_restart_edge", edge_count, 5);
    idle();

    // async reset at bit 6 edge 10
    cfg(16, 8, 0, 0); clr(); counter_enable = 1'b1;
    run(106);
    chk("t6_pos_bit", bit_count, 6);
    chk("t6_pos_edge", edge_count, 10);
    #1 rst = 1'b0;
    #1;
    chk("t6_async_clear", {edge_count, bit_count, busy, samp_en, samp_last, is_start,
                           is_data, is_par, is_stop, frame_done, presc_err}, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    clr();
    run(160);
    chk("t6_busy_cycles", a_busy, 159);
    chk("t6_done", a_done, 1);
    idle();

    // data_len clamping
    cfg(8, 3, 0, 0); clr(); counter_enable = 1'b1;
    run(56);
    chk("t7_min_busy", a_busy, 55);
    chk("t7_min_data", a_data, 40);
    chk("t7_min_done", a_done, 1);
    idle();
    cfg(8, 12, 0, 0); clr(); counter_enable = 1'b1;
    run(88);
    chk("t7_max_busy", a_busy, 87);
    chk("t7_max_data", a_data, 72);
    chk("t7_max_done", a_done, 1);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_bit_timer.md
Name: uart_rx_bit_timer

Overview:
Parametrised oversampling timer for the UART receiver. It counts receive-clock edges within each bit and counts bits within each frame. It supports any even prescale in a configurable range, runtime data length, optional parity and 1 or 2 stop bits. It emits mid-bit majority-sampling strobes, bit-field decodes and a frame-done pulse to the RX FSM, data sampler and deserializer.

Parameters:
PRESCALE_W, 6, width of prescale input and edge counter (max prescale 2^PRESCALE_W-2)
MIN_PRESCALE, 4, smallest legal prescale; must be >=4
MAX_DATA_BITS, 9, upper clamp for data_len; 5..MAX_DATA_BITS legal
BIT_CNT_W, 4, bit counter width; must hold 1+MAX_DATA_BITS+1+2-1

Ports:
clk  in  1  receive oversampling clock
rst  in  1  asynchronous active-low reset
prescale  in  PRESCALE_W  oversampling ratio; even, >=MIN_PRESCALE
data_len  in  4  data bits per frame
par_en  in  1  parity bit present
stop2  in  1  1 = two stop bits, 0 = one
counter_enable  in  1  count while high; low clears
edge_count  out  PRESCALE_W  edge index within current bit
bit_count  out  BIT_CNT_W  bit index within frame (0 = start)
busy  out  1  frame in progress
samp_en  out  1  high on the three majority-sample edges
samp_last  out  1  high on the third sample edge (vote complete)
is_start/is_data/is_par/is_stop  out  1 each  field decode of bit_count while busy
frame_done  out  1  one-cycle pulse after final edge of last stop bit
presc_err  out  1  sticky illegal-configuration flag

Behaviour:
- Decided: one clock, clk; reset rst is asynchronous and active-low. Reset drives every output and internal register to 0.
- Config latch: the first enabled cycle with busy=0 latches P=prescale, L=clamp(data_len,5,MAX_DATA_BITS), par_en and stop2. Later input changes are ignored until the frame ends or is aborted.
- Frame length N = 1 + L + par_en + (stop2 ? 2 : 1).
- Illegal start: prescale < MIN_PRESCALE or prescale odd at the start cycle -> no start. presc_err=1, counters stay 0, busy stays 0. presc_err clears on the next legal start.
- Start cycle: edge_count 0->1 and busy=1 registered, so edge 0 is the start cycle itself.
- Counting, each enabled busy cycle:
  - edge_count==P-1 and bit_count<N-1 -> edge_count=0, bit_count+1.
  - edge_count==P-1 and bit_count==N-1 -> edge_count=0, bit_count=0, busy=0; frame_done=1 in the following cycle, otherwise 0.
  - Otherwise edge_count+1.
- Back-to-back frames: with counter_enable still high after frame end, the next cycle is a new start cycle with a fresh config latch. There is no idle gap beyond that cycle. The frame_done pulse coincides with the new start cycle.
- Strobes, combinational from registers while busy: samp_en when edge_count is P/2-1, P/2 or P/2+1; samp_last when edge_count==P/2+1. Both are 0 when not busy.
- Decodes: is_start when bit_count==0; is_data when 1..L; is_par when par_en and bit_count==L+1; is_stop otherwise. All are 0 when not busy.
- Abort: counter_enable low -> next edge clears edge_count, bit_count and busy. No frame_done.
- Wrap safety: counters never exceed P-1 and N-1.
- Asynchronous reset mid-frame clears immediately. Counting resumes only with a new start cycle after rst deasserts.

Test Plan:
- P=8, L=8, par_en=0, stop2=0, enable held 80 cycles -> N=10. bit_count steps every 8 cycles. samp_en on edges 3,4,5; samp_last on 5. frame_done pulses once, the cycle after bit 9 edge 7.
- P=16, L=7, par_en=1, stop2=1 -> N=11, 176 cycles per frame. is_par at bit 8; is_stop at bits 9-10.
- P=32, L=9, back-to-back 2 frames, prescale changed to 8 mid-frame 1 -> frame 1 uses 32 (352 cycles). frame_done coincides with frame 2 start. Frame 2 uses 8.
- prescale=2, then 7 -> presc_err=1, busy=0, counts stay 0. Then prescale=8 -> presc_err clears, frame runs.
- counter_enable dropped at bit 4 edge 3, P=16 -> counters 0 next cycle, no frame_done. Re-enable restarts at bit 0.
- rst low asynchronously at bit 6 edge 10 -> all outputs 0 without a clock edge. Release with enable high -> clean frame.
- data_len=3 and 12 -> clamped to 5 and 9 (N=7 and 11 with par_en=0, stop2=0).
